// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer
//
// Command sequencer for an 8-bit universal shift register. It accepts one
// command per valid/ready handshake: an optional parallel load followed by N
// shifts in a single direction. It drives the register's control lines with
// the matching single-cycle pulses, then reads back the register's parallel
// output and returns it on a valid/ready response port.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_load          1 = parallel load cmd_data before shifting
//   cmd_data          value to load
//   cmd_dir           0 = shift left, 1 = shift right
//   cmd_count         number of shift cycles
//   sr_enable         shift register enable
//   sr_parallel_load  shift register parallel_load
//   sr_shift_left     shift register shift_left
//   sr_shift_right    shift register shift_right
//   sr_data_in        shift register data_in (zero outside the load cycle)
//   sr_data_out       shift register data_out (registered in the register)
//   rsp_valid/ready   response handshake
//   rsp_data          register value captured after the command completes
//   busy              high whenever the sequencer is not idle
//
// All outputs are flops. Control outputs are decoded from the next state so
// that they change on the same edge as the state register, which keeps them
// a pure function of the current state as seen from outside.
// -----------------------------------------------------------------------------
module shift_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_enable,
  output logic             sr_parallel_load,
  output logic             sr_shift_left,
  output logic             sr_shift_right,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  // State and latched command
  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // Registered outputs
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             sr_enable_q, sr_enable_d;
  logic             sr_parallel_load_q, sr_parallel_load_d;
  logic             sr_shift_left_q, sr_shift_left_d;
  logic             sr_shift_right_q, sr_shift_right_d;
  logic [WIDTH-1:0] sr_data_in_q, sr_data_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             cmd_accept_s;

  // cmd_ready_q is only ever high in IDLE, so this is the command handshake.
  assign cmd_accept_s = cmd_valid && cmd_ready_q;

  // Next-state, command latch, shift counter and response capture.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          data_d      = cmd_data;
          dir_d       = cmd_dir;
          remaining_d = cmd_count;
          if (cmd_load) begin
            state_d = ST_LOAD;
          end else if (cmd_count != CNT_ZERO) begin
            state_d = ST_SHIFT;
          end else begin
            // Pure read-back: the register is left untouched.
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (remaining_q != CNT_ZERO) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_SHIFT: begin
        // Leaving on remaining<=1 also guards against a zero count ever
        // reaching this state, so the counter cannot wrap.
        if (remaining_q <= CNT_ONE) begin
          remaining_d = CNT_ZERO;
          state_d     = ST_SETTLE;
        end else begin
          remaining_d = remaining_q - CNT_ONE;
          state_d     = ST_SHIFT;
        end
      end

      ST_SETTLE: begin
        // The last shift landed at the previous edge and data_out is
        // registered downstream, so the value is stable here.
        rsp_data_d  = sr_data_out;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle.
        rsp_valid_d = 1'b0;
        remaining_d = CNT_ZERO;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs flip with the state flop.
  always_comb begin
    cmd_ready_d        = 1'b0;
    busy_d             = 1'b1;
    sr_enable_d        = 1'b0;
    sr_parallel_load_d = 1'b0;
    sr_shift_left_d    = 1'b0;
    sr_shift_right_d   = 1'b0;
    sr_data_in_d       = DATA_ZERO;

    case (state_d)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      ST_LOAD: begin
        sr_enable_d        = 1'b1;
        sr_parallel_load_d = 1'b1;
        sr_data_in_d       = data_d;
      end

      ST_SHIFT: begin
        sr_enable_d      = 1'b1;
        sr_shift_left_d  = ~dir_d;
        sr_shift_right_d = dir_d;
      end

      ST_SETTLE: begin
        busy_d = 1'b1;
      end

      ST_RESP: begin
        busy_d = 1'b1;
      end

      default: begin
        // All controls stay inactive for any unexpected encoding.
        busy_d = 1'b1;
      end
    endcase
  end

  // State, command latch and registered outputs with async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      data_q             <= DATA_ZERO;
      dir_q              <= 1'b0;
      remaining_q        <= CNT_ZERO;
      cmd_ready_q        <= 1'b1;
      busy_q             <= 1'b0;
      sr_enable_q        <= 1'b0;
      sr_parallel_load_q <= 1'b0;
      sr_shift_left_q    <= 1'b0;
      sr_shift_right_q   <= 1'b0;
      sr_data_in_q       <= DATA_ZERO;
      rsp_valid_q        <= 1'b0;
      rsp_data_q         <= DATA_ZERO;
    end else begin
      state_q            <= state_d;
      data_q             <= data_d;
      dir_q              <= dir_d;
      remaining_q        <= remaining_d;
      cmd_ready_q        <= cmd_ready_d;
      busy_q             <= busy_d;
      sr_enable_q        <= sr_enable_d;
      sr_parallel_load_q <= sr_parallel_load_d;
      sr_shift_left_q    <= sr_shift_left_d;
      sr_shift_right_q   <= sr_shift_right_d;
      sr_data_in_q       <= sr_data_in_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_data_q         <= rsp_data_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign busy             = busy_q;
  assign sr_enable        = sr_enable_q;
  assign sr_parallel_load = sr_parallel_load_q;
  assign sr_shift_left    = sr_shift_left_q;
  assign sr_shift_right   = sr_shift_right_q;
  assign sr_data_in       = sr_data_in_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
module tb_shift_reg_sequencer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             sr_enable;
  logic             sr_parallel_load;
  logic             sr_shift_left;
  logic             sr_shift_right;
  logic [WIDTH-1:0] sr_data_in;
  logic [WIDTH-1:0] sr_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int errors = 0;
  int checks = 0;

  shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_load         (cmd_load),
    .cmd_data         (cmd_data),
    .cmd_dir          (cmd_dir),
    .cmd_count        (cmd_count),
    .sr_enable        (sr_enable),
    .sr_parallel_load (sr_parallel_load),
    .sr_shift_left    (sr_shift_left),
    .sr_shift_right   (sr_shift_right),
    .sr_data_in       (sr_data_in),
    .sr_data_out      (sr_data_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream universal shift register: load > left > right, zero fill.
  logic [WIDTH-1:0] sreg_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= 8'h00;
    end else if (sr_enable) begin
      if (sr_parallel_load)    sreg_q <= sr_data_in;
      else if (sr_shift_left)  sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      else if (sr_shift_right) sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
    end
  end
  assign sr_data_out = sreg_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and follow it until rsp_valid (bounded).
  task automatic run_cmd(input string tag, input logic load, input logic [7:0] data,
                         input logic dir, input logic [3:0] count, input logic [7:0] exp_data);
    int k, n_pl, n_sl, n_sr, viol;
    logic [7:0] ld;
    k = 0; n_pl = 0; n_sl = 0; n_sr = 0; viol = 0; ld = 8'h00;
    cmd_load = load; cmd_data = data; cmd_dir = dir; cmd_count = count; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && k < 40) begin
      if (sr_parallel_load) begin n_pl++; ld = sr_data_in; end
      if (sr_shift_left) n_sl++;
      if (sr_shift_right) n_sr++;
      if (sr_enable && (int'(sr_parallel_load) + int'(sr_shift_left) + int'(sr_shift_right) != 1)) viol++;
      if (!sr_enable && (sr_parallel_load || sr_shift_left || sr_shift_right)) viol++;
      if (!sr_parallel_load && sr_data_in != 8'h00) viol++;
      if (cmd_ready || !busy) viol++;
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'(int'(load) + int'(count) + 1));
    chk({tag, ".loads"}, 32'(n_pl), 32'(int'(load)));
    chk({tag, ".lefts"}, 32'(n_sl), dir ? 32'd0 : 32'(count));
    chk({tag, ".rights"}, 32'(n_sr), dir ? 32'(count) : 32'd0);
    chk({tag, ".load_data"}, 32'(ld), load ? 32'(data) : 32'd0);
    chk({tag, ".protocol"}, 32'(viol), 32'd0);
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'({cmd_ready, busy}), 32'(2'b10));
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_data = 8'h00;
    cmd_dir = 1'b0; cmd_count = 4'd0; rsp_ready = 1'b1;

    // Asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst.ctrl", 32'({sr_enable, sr_parallel_load, sr_shift_left, sr_shift_right}), 32'd0);
    chk("rst.data_in", 32'(sr_data_in), 32'd0);
    chk("rst.rsp", 32'({rsp_valid, rsp_data}), 32'd0);
    chk("rst.ready_busy", 32'({cmd_ready, busy}), 32'(2'b10));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.release_ready", 32'(cmd_ready), 32'd1);

    run_cmd("load_only", 1'b1, 8'hA5, 1'b0, 4'd0, 8'hA5);
    finish_rsp("load_only");
    run_cmd("load_left", 1'b1, 8'b10101010, 1'b0, 4'd3, 8'b01010000);
    finish_rsp("load_left");
    run_cmd("right", 1'b0, 8'h00, 1'b1, 4'd2, 8'b00010100);
    finish_rsp("right");
    run_cmd("readback", 1'b0, 8'h00, 1'b0, 4'd0, 8'b00010100);
    finish_rsp("readback");

    // Reset in the middle of a 10-shift command, after 4 shifts
    cmd_load = 1'b1; cmd_data = 8'h0F; cmd_dir = 1'b0; cmd_count = 4'd10; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midshift.shifting", 32'({sr_enable, sr_shift_left}), 32'(2'b11));
    #1 reset = 1'b1;
    #1;
    chk("midshift.ctrl", 32'({sr_enable, sr_parallel_load, sr_shift_left, sr_shift_right}), 32'd0);
    chk("midshift.rsp", 32'({rsp_valid, rsp_data}), 32'd0);
    chk("midshift.ready_busy", 32'({cmd_ready, busy}), 32'(2'b10));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midshift.no_rsp", 32'({rsp_valid, sr_enable, cmd_ready}), 32'(3'b001));
    end
    run_cmd("post_reset", 1'b1, 8'h3C, 1'b0, 4'd0, 8'h3C);
    finish_rsp("post_reset");

    // Overshift with response backpressure; commands during the hold are ignored
    rsp_ready = 1'b0;
    run_cmd("overshift", 1'b1, 8'hFF, 1'b0, 4'd15, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = (i % 2 == 0); cmd_load = 1'b1; cmd_data = 8'h77; cmd_count = 4'd0;
      @(negedge clk);
      chk("bp.rsp_hold", 32'({rsp_valid, rsp_data}), 32'h100);
      chk("bp.ready_busy", 32'({cmd_ready, busy, sr_enable}), 32'(3'b010));
    end
    cmd_valid = 1'b0;
    finish_rsp("bp");
    run_cmd("after_bp", 1'b0, 8'h00, 1'b0, 4'd0, 8'h00);
    finish_rsp("after_bp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
